// File: rtl/shim_integrator_ctrl.sv
// -----------------------------------------------------------------------------
// shim_integrator_ctrl
//
// Sequencing controller for the shim threshold integrator. An accepted arm
// latches the window/threshold configuration. The controller then validates
// the window and holds the integrator in reset for RESET_CYCLES. It enables
// the integrator and waits up to SETUP_TIMEOUT cycles for setup to complete,
// then monitors the integrator's fault flags while running. Any fault latches
// a coded cause and raises shutdown_req until software clears it.
//
// Ports
//   clk                  system clock (single domain)
//   rst                  asynchronous, active-high reset
//   cfg_window[31:0]     integration window in clocks, sampled on accepted arm
//   cfg_threshold[14:0]  average-magnitude threshold, sampled on accepted arm
//   arm                  start request, honoured only in IDLE
//   disarm               stop request, honoured in START and RUN
//   clear                fault acknowledge, honoured only in FAULT
//   integ_resetn         active-low reset to the integrator
//   integ_enable         integrator enable
//   integ_window[31:0]   latched window
//   integ_threshold[14:0] latched threshold
//   integ_setup_done     integrator setup complete
//   integ_over_thresh    integrator threshold trip
//   integ_err_overflow   integrator FIFO overflow
//   integ_err_underflow  integrator FIFO underflow
//   state[2:0]           current state encoding
//   running              high while in RUN
//   fault                high while in FAULT
//   fault_code[2:0]      latched fault cause
//   shutdown_req         high while in FAULT
//   run_cycles[31:0]     cycles spent in the current or last RUN (saturating)
// -----------------------------------------------------------------------------
module shim_integrator_ctrl #(
    parameter int unsigned RESET_CYCLES  = 4,      // 1..255
    parameter int unsigned SETUP_TIMEOUT = 65536,  // 1..2^24
    parameter int unsigned MIN_WINDOW    = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cfg_window,
    input  logic [14:0] cfg_threshold,
    input  logic        arm,
    input  logic        disarm,
    input  logic        clear,
    output logic        integ_resetn,
    output logic        integ_enable,
    output logic [31:0] integ_window,
    output logic [14:0] integ_threshold,
    input  logic        integ_setup_done,
    input  logic        integ_over_thresh,
    input  logic        integ_err_overflow,
    input  logic        integ_err_underflow,
    output logic [2:0]  state,
    output logic        running,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic        shutdown_req,
    output logic [31:0] run_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CHECK       = 3'd1,
        ST_RESET_INTEG = 3'd2,
        ST_START       = 3'd3,
        ST_RUN         = 3'd4,
        ST_STOP        = 3'd5,
        ST_FAULT       = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        FC_NONE          = 3'd0,
        FC_BAD_WINDOW    = 3'd1,
        FC_SETUP_TIMEOUT = 3'd2,
        FC_OVER_THRESH   = 3'd3,
        FC_OVERFLOW      = 3'd4,
        FC_UNDERFLOW     = 3'd5
    } fault_code_e;

    // One shared down-the-line counter: reset/stop hold length and START
    // timeout are never active at the same time. 24 bits covers the largest
    // legal timeout (terminal count SETUP_TIMEOUT-1 <= 2^24-1).
    localparam logic [23:0] RESET_LAST   = 24'(RESET_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(SETUP_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [31:0] window_d;
    logic [14:0] threshold_d;
    logic [2:0]  fault_code_d;
    logic [31:0] run_cycles_d;

    assign state = state_q;

    // -------------------------------------------------------------------------
    // Next-state and next-register logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        window_d     = integ_window;
        threshold_d  = integ_threshold;
        fault_code_d = fault_code;
        run_cycles_d = run_cycles;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    window_d     = cfg_window;
                    threshold_d  = cfg_threshold;
                    run_cycles_d = '0;
                    state_d      = ST_CHECK;
                end
            end

            ST_CHECK: begin
                cnt_d = '0;
                if (integ_window < MIN_WINDOW) begin
                    fault_code_d = FC_BAD_WINDOW;
                    state_d      = ST_FAULT;
                end else begin
                    state_d = ST_RESET_INTEG;
                end
            end

            ST_RESET_INTEG: begin
                if (cnt_q == RESET_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end

            ST_START: begin
                // disarm > setup_done > timeout
                if (disarm) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else if (integ_setup_done) begin
                    state_d = ST_RUN;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fault_code_d = FC_SETUP_TIMEOUT;
                    state_d      = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end

            ST_RUN: begin
                if (run_cycles != 32'hFFFF_FFFF) begin
                    run_cycles_d = run_cycles + 32'd1;
                end
                // Faults beat disarm; overflow > underflow > over_thresh.
                if (integ_err_overflow) begin
                    fault_code_d = FC_OVERFLOW;
                    state_d      = ST_FAULT;
                end else if (integ_err_underflow) begin
                    fault_code_d = FC_UNDERFLOW;
                    state_d      = ST_FAULT;
                end else if (integ_over_thresh) begin
                    fault_code_d = FC_OVER_THRESH;
                    state_d      = ST_FAULT;
                end else if (disarm) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (cnt_q == RESET_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end

            ST_FAULT: begin
                if (clear) begin
                    fault_code_d = FC_NONE;
                    state_d      = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next state so
    // they change on the same edge as the state they describe.
    // -------------------------------------------------------------------------
    // NOTE: every register, including the configuration latches, is reset so
    // that all outputs show defined values the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            integ_window    <= '0;
            integ_threshold <= '0;
            fault_code      <= '0;
            run_cycles      <= '0;
            integ_resetn    <= 1'b0;
            integ_enable    <= 1'b0;
            running         <= 1'b0;
            fault           <= 1'b0;
            shutdown_req    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            integ_window    <= window_d;
            integ_threshold <= threshold_d;
            fault_code      <= fault_code_d;
            run_cycles      <= run_cycles_d;
            // FAULT keeps the integrator out of reset so its flags remain
            // readable while the cause is investigated.
            integ_resetn    <= (state_d == ST_START) || (state_d == ST_RUN) ||
                               (state_d == ST_FAULT);
            integ_enable    <= (state_d == ST_START) || (state_d == ST_RUN);
            running         <= (state_d == ST_RUN);
            fault           <= (state_d == ST_FAULT);
            shutdown_req    <= (state_d == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_shim_integrator_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shim_integrator_ctrl
//
// Directed scenarios plus randomized arm/run/terminate sequences for
// shim_integrator_ctrl. A second instance with a short setup timeout is used
// for the timeout scenarios; both instances share all inputs.
// -----------------------------------------------------------------------------
module tb_shim_integrator_ctrl;

    localparam int RC      = 4;
    localparam int TO      = 16;
    localparam int MIN_WIN = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_window;
    logic [14:0] cfg_threshold;
    logic        arm, disarm, clear;
    logic        integ_setup_done, integ_over_thresh;
    logic        integ_err_overflow, integ_err_underflow;

    logic        integ_resetn, integ_enable;
    logic [31:0] integ_window;
    logic [14:0] integ_threshold;
    logic [2:0]  state;
    logic        running, fault;
    logic [2:0]  fault_code;
    logic        shutdown_req;
    logic [31:0] run_cycles;

    logic        to_integ_resetn, to_integ_enable;
    logic [31:0] to_integ_window;
    logic [14:0] to_integ_threshold;
    logic [2:0]  to_state;
    logic        to_running, to_fault;
    logic [2:0]  to_fault_code;
    logic        to_shutdown_req;
    logic [31:0] to_run_cycles;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    shim_integrator_ctrl #(.RESET_CYCLES(RC)) u_dut (
        .clk(clk), .rst(rst),
        .cfg_window(cfg_window), .cfg_threshold(cfg_threshold),
        .arm(arm), .disarm(disarm), .clear(clear),
        .integ_resetn(integ_resetn), .integ_enable(integ_enable),
        .integ_window(integ_window), .integ_threshold(integ_threshold),
        .integ_setup_done(integ_setup_done), .integ_over_thresh(integ_over_thresh),
        .integ_err_overflow(integ_err_overflow), .integ_err_underflow(integ_err_underflow),
        .state(state), .running(running), .fault(fault), .fault_code(fault_code),
        .shutdown_req(shutdown_req), .run_cycles(run_cycles)
    );

    shim_integrator_ctrl #(.RESET_CYCLES(RC), .SETUP_TIMEOUT(TO)) u_to (
        .clk(clk), .rst(rst),
        .cfg_window(cfg_window), .cfg_threshold(cfg_threshold),
        .arm(arm), .disarm(disarm), .clear(clear),
        .integ_resetn(to_integ_resetn), .integ_enable(to_integ_enable),
        .integ_window(to_integ_window), .integ_threshold(to_integ_threshold),
        .integ_setup_done(integ_setup_done), .integ_over_thresh(integ_over_thresh),
        .integ_err_overflow(integ_err_overflow), .integ_err_underflow(integ_err_underflow),
        .state(to_state), .running(to_running), .fault(to_fault), .fault_code(to_fault_code),
        .shutdown_req(to_shutdown_req), .run_cycles(to_run_cycles)
    );

    function automatic logic [89:0] main_outs();
        return {integ_resetn, integ_enable, integ_window, integ_threshold, state,
                running, fault, fault_code, shutdown_req, run_cycles};
    endfunction

    function automatic logic [89:0] to_outs();
        return {to_integ_resetn, to_integ_enable, to_integ_window, to_integ_threshold, to_state,
                to_running, to_fault, to_fault_code, to_shutdown_req, to_run_cycles};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        cfg_window = '0; cfg_threshold = '0;
        arm = 0; disarm = 0; clear = 0;
        integ_setup_done = 0; integ_over_thresh = 0;
        integ_err_overflow = 0; integ_err_underflow = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        step(2);
        rst = 0;
        step(1);
    endtask

    // Arm from IDLE, wait out the reset hold, then complete setup after
    // 'delay' START cycles. Returns with the block in RUN.
    task automatic go_run(input logic [31:0] w, input logic [14:0] t, input int delay);
        cfg_window = w; cfg_threshold = t; arm = 1;
        step(1);
        arm = 0;
        step(RC + 1);
        step(delay);
        integ_setup_done = 1;
        step(1);
        integ_setup_done = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #2;
        tests_run++;
        if (main_outs() !== '0) begin tests_failed++; $display("FAIL reset_values: outs=%0h expected 0", main_outs()); end
        step(2);
        rst = 0;
        step(1);
        tests_run++;
        if (main_outs() !== '0) begin tests_failed++; $display("FAIL idle_after_reset: outs=%0h expected 0", main_outs()); end
    endtask

    task automatic test_nominal();
        int low_cnt;
        cfg_window = 32'h0001_0000; cfg_threshold = 15'd100; arm = 1;
        step(1);
        arm = 0;
        tests_run++;
        if (state !== 3'd1) begin tests_failed++; $display("FAIL arm_to_check: state=%0d expected 1", state); end
        tests_run++;
        if (integ_window !== 32'h0001_0000 || integ_threshold !== 15'd100) begin
            tests_failed++; $display("FAIL cfg_latched: window=%0h thr=%0d expected 10000/100", integ_window, integ_threshold);
        end
        low_cnt = 0;
        for (int i = 0; i < RC; i++) begin
            step(1);
            if (state == 3'd2 && integ_resetn == 1'b0 && integ_enable == 1'b0) low_cnt++;
        end
        tests_run++;
        if (low_cnt !== RC) begin tests_failed++; $display("FAIL reset_hold: cycles=%0d expected %0d", low_cnt, RC); end
        step(1);
        tests_run++;
        if ({state, integ_resetn, integ_enable} !== {3'd3, 1'b1, 1'b1}) begin
            tests_failed++; $display("FAIL start_entry: state=%0d resetn=%b en=%b expected 3/1/1", state, integ_resetn, integ_enable);
        end
        step(20);
        tests_run++;
        if (running !== 1'b0 || state !== 3'd3) begin tests_failed++; $display("FAIL start_wait: state=%0d running=%b expected 3/0", state, running); end
        integ_setup_done = 1;
        step(1);
        integ_setup_done = 0;
        tests_run++;
        if (running !== 1'b1 || state !== 3'd4) begin tests_failed++; $display("FAIL run_entry: state=%0d running=%b expected 4/1", state, running); end
        step(10);
        tests_run++;
        if (run_cycles !== 32'd10) begin tests_failed++; $display("FAIL run_count10: run_cycles=%0d expected 10", run_cycles); end
        disarm = 1;
        step(1);
        disarm = 0;
        step(RC);
        tests_run++;
        if (state !== 3'd0 || integ_resetn !== 1'b0) begin tests_failed++; $display("FAIL nominal_back_idle: state=%0d resetn=%b expected 0/0", state, integ_resetn); end
    endtask

    task automatic test_bad_window();
        logic [31:0] bad [2];
        logic        en_seen;
        bad[0] = 32'd1000;
        bad[1] = 32'd2047;
        for (int k = 0; k < 2; k++) begin
            en_seen = 0;
            cfg_window = bad[k]; arm = 1;
            step(1);
            arm = 0;
            en_seen |= integ_enable;
            step(1);
            en_seen |= integ_enable;
            tests_run++;
            if ({state, fault_code, fault, shutdown_req} !== {3'd6, 3'd1, 1'b1, 1'b1}) begin
                tests_failed++; $display("FAIL bad_window_%0d: state=%0d code=%0d fault=%b sd=%b expected 6/1/1/1", bad[k], state, fault_code, fault, shutdown_req);
            end
            step(3);
            en_seen |= integ_enable;
            tests_run++;
            if (en_seen !== 1'b0 || state !== 3'd6) begin tests_failed++; $display("FAIL bad_window_hold: en_seen=%b state=%0d expected 0/6", en_seen, state); end
            clear = 1;
            step(1);
            clear = 0;
            tests_run++;
            if (state !== 3'd0 || fault_code !== 3'd0) begin tests_failed++; $display("FAIL bad_window_clear: state=%0d code=%0d expected 0/0", state, fault_code); end
        end
        // Exactly MIN_WINDOW is legal; disarm before START is ignored;
        // disarm beats setup_done in START.
        cfg_window = 32'd2048; arm = 1;
        step(1);
        arm = 0;
        step(1);
        tests_run++;
        if (state !== 3'd2) begin tests_failed++; $display("FAIL min_window_ok: state=%0d expected 2", state); end
        disarm = 1;
        step(1);
        disarm = 0;
        tests_run++;
        if (state !== 3'd2) begin tests_failed++; $display("FAIL disarm_in_reset_ignored: state=%0d expected 2", state); end
        step(RC - 1);
        tests_run++;
        if (state !== 3'd3) begin tests_failed++; $display("FAIL start_after_disarm_ignored: state=%0d expected 3", state); end
        disarm = 1; integ_setup_done = 1;
        step(1);
        disarm = 0; integ_setup_done = 0;
        tests_run++;
        if (state !== 3'd5 || running !== 1'b0) begin tests_failed++; $display("FAIL disarm_beats_setup: state=%0d running=%b expected 5/0", state, running); end
        step(RC);
        tests_run++;
        if (state !== 3'd0) begin tests_failed++; $display("FAIL stop_to_idle: state=%0d expected 0", state); end
    endtask

    task automatic test_timeout();
        int cyc;
        apply_reset();
        cfg_window = 32'h0000_1000; arm = 1;
        step(1);
        arm = 0;
        step(RC + 1);
        tests_run++;
        if (to_state !== 3'd3) begin tests_failed++; $display("FAIL to_start_entry: state=%0d expected 3", to_state); end
        cyc = 0;
        while (to_state == 3'd3 && cyc < 100) begin
            step(1);
            cyc++;
        end
        tests_run++;
        if (cyc !== TO || to_state !== 3'd6 || to_fault_code !== 3'd2) begin
            tests_failed++; $display("FAIL setup_timeout: cycles=%0d state=%0d code=%0d expected %0d/6/2", cyc, to_state, to_fault_code, TO);
        end
        tests_run++;
        if (state !== 3'd3) begin tests_failed++; $display("FAIL long_timeout_waits: state=%0d expected 3", state); end
        // setup_done on the very last START cycle wins over the timeout.
        apply_reset();
        cfg_window = 32'h0000_1000; arm = 1;
        step(1);
        arm = 0;
        step(RC + 1);
        step(TO - 1);
        tests_run++;
        if (to_state !== 3'd3) begin tests_failed++; $display("FAIL timeout_not_early: state=%0d expected 3", to_state); end
        integ_setup_done = 1;
        step(1);
        integ_setup_done = 0;
        tests_run++;
        if (to_state !== 3'd4 || to_running !== 1'b1 || to_fault_code !== 3'd0) begin
            tests_failed++; $display("FAIL setup_beats_timeout: state=%0d running=%b code=%0d expected 4/1/0", to_state, to_running, to_fault_code);
        end
        apply_reset();
    endtask

    task automatic test_fault_vs_disarm();
        go_run(32'h0000_4000, 15'd500, 3);
        step(5);
        integ_over_thresh = 1; disarm = 1;
        step(1);
        integ_over_thresh = 0; disarm = 0;
        tests_run++;
        if ({state, fault_code, integ_enable, integ_resetn, shutdown_req, running} !== {3'd6, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            tests_failed++; $display("FAIL fault_beats_disarm: state=%0d code=%0d en=%b rn=%b sd=%b run=%b expected 6/3/0/1/1/0",
                                     state, fault_code, integ_enable, integ_resetn, shutdown_req, running);
        end
        step(3);
        tests_run++;
        if (state !== 3'd6 || fault_code !== 3'd3) begin tests_failed++; $display("FAIL fault_hold: state=%0d code=%0d expected 6/3", state, fault_code); end
        clear = 1;
        step(1);
        clear = 0;
        tests_run++;
        if ({state, fault_code, integ_resetn, shutdown_req, fault} !== {3'd0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++; $display("FAIL clear_to_idle: state=%0d code=%0d rn=%b sd=%b expected 0/0/0/0", state, fault_code, integ_resetn, shutdown_req);
        end
        go_run(32'h0000_4000, 15'd500, 0);
        integ_err_overflow = 1; integ_err_underflow = 1;
        step(1);
        integ_err_overflow = 0; integ_err_underflow = 0;
        tests_run++;
        if (state !== 3'd6 || fault_code !== 3'd4) begin tests_failed++; $display("FAIL ovf_over_unf: state=%0d code=%0d expected 6/4", state, fault_code); end
        clear = 1;
        step(1);
        clear = 0;
    endtask

    task automatic test_run_length_and_ignored();
        int stop_seen;
        go_run(32'h0001_0000, 15'd77, 2);
        // arm and clear in RUN are ignored; configuration stays put.
        cfg_window = 32'hDEAD_BEEF; cfg_threshold = 15'h1234; arm = 1; clear = 1;
        step(1);
        arm = 0; clear = 0;
        tests_run++;
        if (state !== 3'd4 || integ_window !== 32'h0001_0000 || integ_threshold !== 15'd77) begin
            tests_failed++; $display("FAIL arm_in_run_ignored: state=%0d window=%0h thr=%0d expected 4/10000/77", state, integ_window, integ_threshold);
        end
        step(498);
        disarm = 1;
        step(1);
        disarm = 0;
        tests_run++;
        if (state !== 3'd5 || run_cycles !== 32'd500 || integ_enable !== 1'b0) begin
            tests_failed++; $display("FAIL disarm_run500: state=%0d run_cycles=%0d en=%b expected 5/500/0", state, run_cycles, integ_enable);
        end
        stop_seen = 1;
        repeat (RC - 1) begin
            step(1);
            if (state == 3'd5 && integ_resetn == 1'b0) stop_seen++;
        end
        tests_run++;
        if (stop_seen !== RC) begin tests_failed++; $display("FAIL stop_length: cycles=%0d expected %0d", stop_seen, RC); end
        step(1);
        tests_run++;
        if (state !== 3'd0 || run_cycles !== 32'd500) begin tests_failed++; $display("FAIL idle_run_frozen: state=%0d run_cycles=%0d expected 0/500", state, run_cycles); end
        disarm = 1; clear = 1;
        step(2);
        disarm = 0; clear = 0;
        tests_run++;
        if (state !== 3'd0) begin tests_failed++; $display("FAIL idle_ignores_disarm: state=%0d expected 0", state); end
    endtask

    task automatic test_rst_mid_op();
        go_run(32'h0002_0000, 15'd9, 1);
        step(7);
        #2;
        rst = 1;
        #1;
        tests_run++;
        if (main_outs() !== '0 || to_outs() !== '0) begin tests_failed++; $display("FAIL rst_in_run: outs=%0h expected 0", main_outs()); end
        step(1);
        rst = 0;
        step(1);
        go_run(32'h0002_0000, 15'd9, 1);
        integ_err_underflow = 1;
        step(1);
        integ_err_underflow = 0;
        tests_run++;
        if (state !== 3'd6 || fault_code !== 3'd5) begin tests_failed++; $display("FAIL underflow_fault: state=%0d code=%0d expected 6/5", state, fault_code); end
        #2;
        rst = 1;
        #1;
        tests_run++;
        if (main_outs() !== '0) begin tests_failed++; $display("FAIL rst_in_fault: outs=%0h expected 0", main_outs()); end
        step(1);
        rst = 0;
        step(1);
    endtask

    // Random arm/run/terminate sequences. Expected values come from the
    // scenario parameters alone: bad window -> code 1 two cycles after arm;
    // otherwise run_cycles equals the number of RUN cycles, and the final
    // cause is the highest-priority raised flag, else a clean STOP.
    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [31:0] w;
            logic [14:0] t;
            logic [2:0]  flags;  // {overflow, underflow, over_thresh}
            int          d, len, sel;
            logic [2:0]  exp_code;
            logic [2:0]  exp_state;
            sel = $urandom_range(0, 3);
            if (sel == 0)      w = 32'($urandom_range(0, MIN_WIN - 1));
            else if (sel == 1) w = 32'(MIN_WIN + $urandom_range(0, 64));
            else               w = $urandom;
            t     = 15'($urandom);
            d     = $urandom_range(0, 12);
            len   = $urandom_range(1, 40);
            flags = 3'($urandom_range(0, 7));

            cfg_window = w; cfg_threshold = t; arm = 1;
            step(1);
            arm = 0;
            tests_run++;
            if (integ_window !== w || integ_threshold !== t || run_cycles !== 32'd0) begin
                tests_failed++; $display("FAIL rnd_latch[%0d]: window=%0h thr=%0h rc=%0d expected %0h/%0h/0", it, integ_window, integ_threshold, run_cycles, w, t);
            end
            if (w < MIN_WIN) begin
                step(1);
                tests_run++;
                if (state !== 3'd6 || fault_code !== 3'd1) begin
                    tests_failed++; $display("FAIL rnd_badwin[%0d]: state=%0d code=%0d expected 6/1", it, state, fault_code);
                end
                clear = 1;
                step(1);
                clear = 0;
            end else begin
                step(RC + 1);
                step(d);
                integ_setup_done = 1;
                step(1);
                integ_setup_done = 0;
                step(len - 1);
                integ_err_overflow  = flags[2];
                integ_err_underflow = flags[1];
                integ_over_thresh   = flags[0];
                disarm = (flags == 3'd0) ? 1'b1 : 1'($urandom_range(0, 1));
                step(1);
                integ_err_overflow = 0; integ_err_underflow = 0; integ_over_thresh = 0; disarm = 0;
                if (flags[2])      exp_code = 3'd4;
                else if (flags[1]) exp_code = 3'd5;
                else if (flags[0]) exp_code = 3'd3;
                else               exp_code = 3'd0;
                exp_state = (exp_code != 3'd0) ? 3'd6 : 3'd5;
                tests_run++;
                if (state !== exp_state || fault_code !== exp_code || run_cycles !== 32'(len)) begin
                    tests_failed++; $display("FAIL rnd_run[%0d]: state=%0d code=%0d rc=%0d expected %0d/%0d/%0d",
                                             it, state, fault_code, run_cycles, exp_state, exp_code, len);
                end
                if (exp_code != 3'd0) begin
                    clear = 1;
                    step(1);
                    clear = 0;
                end else begin
                    step(RC);
                end
            end
            tests_run++;
            if (state !== 3'd0) begin tests_failed++; $display("FAIL rnd_idle[%0d]: state=%0d expected 0", it, state); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_bad_window();
        test_timeout();
        test_fault_vs_disarm();
        test_run_length_and_ignored();
        test_rst_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
